// File: rtl/bmp_stream_sender.sv
// bmp_stream_sender
//
// Slave-side frame source for the image processing accelerator. It accepts a
// frame descriptor, reads the frame's pixel words from a local synchronous image
// memory through a 2-entry FIFO, and drives them onto one accelerator slave port
// while honouring the ready backpressure.
//
// Optional feature: define SENDER_CHECKSUM_EN to enable the running XOR checksum of
// every word that handshakes in the current frame. Without it, checksum_o is tied to 0.
//
// Ports:
//   clk_i, rst_ni         clock and asynchronous active-low reset
//   start_i               frame request, only honoured in idle
//   cfg_mode_i            frame mode
//   cfg_proc_val_i        frame processing value
//   cfg_base_addr_i       first word address
//   cfg_num_words_i       number of words to send
//   busy_o, done_o        frame in progress / one-cycle end-of-frame pulse
//   mem_rd_en_o           image memory read strobe
//   mem_addr_o            image memory read address
//   mem_rd_data_i         read data, valid the cycle after the strobe
//   slv_mode_o            slave port frame mode
//   slv_proc_val_o        slave port processing value
//   slv_data_o            slave port data word
//   slv_data_valid_o      slave port data valid
//   slv_ready_i           slave port ready
//   checksum_o            frame checksum
module bmp_stream_sender #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned CNT_WIDTH  = 11,
    parameter int unsigned COLOR_SIZE = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [1:0]            cfg_mode_i,
    input  logic [COLOR_SIZE-1:0] cfg_proc_val_i,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr_i,
    input  logic [CNT_WIDTH-1:0]  cfg_num_words_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
    output logic [1:0]            slv_mode_o,
    output logic [COLOR_SIZE-1:0] slv_proc_val_o,
    output logic [DATA_WIDTH-1:0] slv_data_o,
    output logic                  slv_data_valid_o,
    input  logic                  slv_ready_i,
    output logic [DATA_WIDTH-1:0] checksum_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [COLOR_SIZE-1:0] pv_q, pv_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_WIDTH-1:0]  fetch_q, fetch_d;
    logic [CNT_WIDTH-1:0]  send_q, send_d;
    logic [DATA_WIDTH-1:0] fifo_q [2];
    logic [DATA_WIDTH-1:0] fifo_d [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  inflight_q;

    logic       accept;
    logic       valid;
    logic       pop;
    logic       rd_en;
    logic [2:0] occ;

    assign accept = (state_q == StIdle) && start_i;
    assign valid  = (count_q != 2'd0);
    assign pop    = valid && slv_ready_i;

    // Space accounting credits the word leaving this cycle so a steady ready
    // stream sustains one word per cycle. count + inflight >= pop always holds.
    assign occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd_en = (state_q == StRun) && (fetch_q != '0) && (occ < 3'd2);

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        pv_d     = pv_q;
        addr_d   = addr_q;
        fetch_d  = fetch_q;
        send_d   = send_q;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + {1'b0, inflight_q} - {1'b0, pop};

        if (inflight_q) begin
            fifo_d[wr_ptr_q] = mem_rd_data_i;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    mode_d  = cfg_mode_i;
                    pv_d    = cfg_proc_val_i;
                    addr_d  = cfg_base_addr_i;
                    fetch_d = cfg_num_words_i;
                    send_d  = cfg_num_words_i;
                    state_d = (cfg_num_words_i == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (rd_en) begin
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    fetch_d = fetch_q - CNT_WIDTH'(1);
                end
                if (pop) begin
                    send_d = send_q - CNT_WIDTH'(1);
                    if (send_q == CNT_WIDTH'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            mode_q     <= '0;
            pv_q       <= '0;
            addr_q     <= '0;
            fetch_q    <= '0;
            send_q     <= '0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            pv_q       <= pv_d;
            addr_q     <= addr_d;
            fetch_q    <= fetch_d;
            send_q     <= send_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= rd_en;
        end
    end

    assign busy_o           = (state_q == StRun);
    assign done_o           = (state_q == StDone);
    assign mem_rd_en_o      = rd_en;
    assign mem_addr_o       = addr_q;
    assign slv_mode_o       = busy_o ? mode_q : 2'b00;
    assign slv_proc_val_o   = busy_o ? pv_q : '0;
    assign slv_data_valid_o = valid;
    assign slv_data_o       = valid ? fifo_q[rd_ptr_q] : '0;

`ifdef SENDER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] ck_q, ck_d;

    always_comb begin
        ck_d = ck_q;
        if (accept) begin
            ck_d = '0;
        end else if (pop) begin
            ck_d = ck_q ^ fifo_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ck_q <= '0;
        end else begin
            ck_q <= ck_d;
        end
    end

    assign checksum_o = ck_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign checksum_o    = '0;
`endif

endmodule

// File: tb/tb_bmp_stream_sender.sv
module tb_bmp_stream_sender;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int CW = 11;
    localparam int CS = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    cfg_mode = '0;
    logic [CS-1:0] cfg_proc_val = '0;
    logic [AW-1:0] cfg_base_addr = '0;
    logic [CW-1:0] cfg_num_words = '0;
    logic          busy, done, mem_rd_en, slv_data_valid;
    logic          slv_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic [1:0]    slv_mode;
    logic [CS-1:0] slv_proc_val;
    logic [DW-1:0] slv_data, checksum;

    bmp_stream_sender dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .start_i          (start),
        .cfg_mode_i       (cfg_mode),
        .cfg_proc_val_i   (cfg_proc_val),
        .cfg_base_addr_i  (cfg_base_addr),
        .cfg_num_words_i  (cfg_num_words),
        .busy_o           (busy),
        .done_o           (done),
        .mem_rd_en_o      (mem_rd_en),
        .mem_addr_o       (mem_addr),
        .mem_rd_data_i    (mem_rd_data),
        .slv_mode_o       (slv_mode),
        .slv_proc_val_o   (slv_proc_val),
        .slv_data_o       (slv_data),
        .slv_data_valid_o (slv_data_valid),
        .slv_ready_i      (slv_ready),
        .checksum_o       (checksum)
    );

    always #5 clk = ~clk;

    // Behavioural image memory: one-cycle synchronous read.
    logic [DW-1:0] mem [1024];
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    logic [DW-1:0] exp_data[$];
    logic [AW-1:0] exp_addr[$];
    logic [1:0]    exp_mode;
    logic [CS-1:0] exp_pv;
    logic [DW-1:0] exp_ck = '0;
    int acc, first_hs_cyc, first_rd_cyc, done_cyc;
    int hs_count = 0;
    int done_cnt = 0;
    bit prev_stall = 0;
    logic [DW-1:0] prev_data;
    int ready_mode = 0;
    int rc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=event required=none", nm);
    endtask

    // Ready driver: 0 = always ready, 1 = random, 2 = 1010 toggle with a 5-cycle low stretch.
    always @(posedge clk) begin
        #1;
        rc++;
        case (ready_mode)
            0: slv_ready = 1'b1;
            1: slv_ready = ($urandom_range(0, 3) != 0);
            default: slv_ready = ((rc % 16) >= 6 && (rc % 16) <= 10) ? 1'b0 : ((rc % 2) == 0);
        endcase
    end

    // Monitor: samples on the falling edge, the transfer itself happens on the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                chk("hold_valid", 64'(slv_data_valid), 64'd1);
                chk("hold_data", 64'(slv_data), 64'(prev_data));
            end
            prev_stall = slv_data_valid && !slv_ready;
            prev_data  = slv_data;
            if (mem_rd_en) begin
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                if (exp_addr.size() == 0) fail("extra_read");
                else chk("rd_addr", 64'(mem_addr), 64'(exp_addr.pop_front()));
            end
            if (slv_data_valid && slv_ready) begin
                if (hs_count == 0) first_hs_cyc = cyc;
                hs_count++;
                if (exp_data.size() == 0) fail("extra_word");
                else chk("word", 64'(slv_data), 64'(exp_data.pop_front()));
                chk("mode", 64'(slv_mode), 64'(exp_mode));
                chk("proc_val", 64'(slv_proc_val), 64'(exp_pv));
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_busy", 64'(busy), 64'd0);
                chk("done_mode", 64'(slv_mode), 64'd0);
                chk("checksum", 64'(checksum), 64'(exp_ck));
            end
        end else begin
            prev_stall = 0;
        end
    end

    task automatic start_frame(input logic [AW-1:0] base, input int n, input logic [1:0] mode,
                               input logic [CS-1:0] pv);
        int t = 0;
        logic [DW-1:0] ck = '0;
        logic [AW-1:0] a;
        @(posedge clk); #1;
        while ((busy || done) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) fail("idle_timeout");
        exp_mode = mode;
        exp_pv   = pv;
        for (int i = 0; i < n; i++) begin
            a = base + AW'(i);
            exp_addr.push_back(a);
            exp_data.push_back(mem[a]);
            ck ^= mem[a];
        end
`ifdef SENDER_CHECKSUM_EN
        exp_ck = ck;
`else
        exp_ck = '0;
`endif
        hs_count = 0;
        first_hs_cyc = -1;
        first_rd_cyc = -1;
        done_cyc = -1;
        cfg_mode = mode;
        cfg_proc_val = pv;
        cfg_base_addr = base;
        cfg_num_words = CW'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        acc = cyc;
        // Scramble the descriptor to prove it was latched.
        cfg_mode = 2'($urandom);
        cfg_proc_val = CS'($urandom);
        cfg_base_addr = AW'($urandom);
        cfg_num_words = CW'($urandom);
    endtask

    task automatic wait_done(input int bound);
        int t = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && t < bound) begin
            @(negedge clk); #1;
            t++;
        end
        if (done_cnt == d0) fail("done_timeout");
        chk("words_left", 64'(exp_data.size()), 64'd0);
        chk("reads_left", 64'(exp_addr.size()), 64'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("single_done", 64'(done_cnt), 64'(d0 + 1));
        chk("checksum_hold", 64'(checksum), 64'(exp_ck));
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_rd_en"}, 64'(mem_rd_en), 64'd0);
        chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_mode"}, 64'(slv_mode), 64'd0);
        chk({tag, "_pv"}, 64'(slv_proc_val), 64'd0);
        chk({tag, "_data"}, 64'(slv_data), 64'd0);
        chk({tag, "_valid"}, 64'(slv_data_valid), 64'd0);
        chk({tag, "_checksum"}, 64'(checksum), 64'd0);
    endtask

    initial begin
        int t;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;

        #12;
        check_outputs_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic frame with full-rate latency checks.
        ready_mode = 0;
        start_frame(10'h000, 4, 2'd2, 8'h40);
        wait_done(60);
        chk("first_rd_lat", 64'(first_rd_cyc - acc), 64'd0);
        chk("first_hs_lat", 64'(first_hs_cyc - acc), 64'd2);
        chk("done_lat", 64'(done_cyc - acc), 64'd6);
`ifdef SENDER_CHECKSUM_EN
        chk("basic_checksum", 64'(checksum), 64'h44);
`else
        chk("basic_checksum", 64'(checksum), 64'h0);
`endif

        // Backpressure with toggling ready and a long low stretch.
        ready_mode = 2;
        start_frame(10'(($urandom_range(0, 1000))), 8, 2'd1, 8'h5A);
        wait_done(200);
        chk("bp_handshakes", 64'(hs_count), 64'd8);

        // Address wrap.
        ready_mode = 1;
        start_frame(10'h3FE, 4, 2'd3, 8'h01);
        wait_done(100);

        // Zero length.
        ready_mode = 0;
        start_frame(10'h123, 0, 2'd1, 8'h77);
        wait_done(20);
        chk("zero_done_lat", 64'(done_cyc - acc), 64'd0);
        chk("zero_hs", 64'(hs_count), 64'd0);
        chk("zero_rd", 64'(first_rd_cyc), 64'hFFFF_FFFF_FFFF_FFFF);

        // Start pulsed mid-frame must be ignored.
        ready_mode = 1;
        start_frame(10'h040, 10, 2'd2, 8'h99);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_mid", 64'(busy), 64'd1);
        cfg_num_words = 11'd3;
        cfg_base_addr = 10'h200;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(200);
        repeat (4) @(negedge clk);
        #1;
        chk("stray_idle", 64'(busy), 64'd0);

        // Mid-frame asynchronous reset.
        ready_mode = 0;
        start_frame(10'h300, 16, 2'd1, 8'h3C);
        t = 0;
        while (hs_count < 5 && t < 300) begin
            @(posedge clk);
            t++;
        end
        if (hs_count < 5) fail("reset_wait_timeout");
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        exp_data.delete();
        exp_addr.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_reset_busy", 64'(busy), 64'd0);
            chk("post_reset_valid", 64'(slv_data_valid), 64'd0);
        end
        start_frame(10'h010, 5, 2'd3, 8'hA5);
        wait_done(100);

        // Randomized frames.
        for (int k = 0; k < 12; k++) begin
            ready_mode = $urandom_range(0, 2);
            start_frame(10'($urandom), $urandom_range(0, 12), 2'($urandom), 8'($urandom));
            wait_done(300);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
